// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if
//   Groups the sequencer's control and status signals into one bundle.
//   master : the environment (drives relock_req / pll_locked, observes status)
//   slave  : the sequencer (observes relock_req / pll_locked, drives status)
//
//   relock_req  single-cycle request to restart the lock sequence
//   pll_locked  raw, asynchronous PLL lock indicator
//   pll_rst     PLL reset
//   core_rst    reset for the core clock domains
//   ready       high while the core is running on a qualified lock
//   fail        high after all lock retries were exhausted
//   lock_lost   one-cycle pulse on unexpected lock loss while running
//   retry_cnt   retries used in the current sequence
interface pll_lock_sequencer_if;
  logic       relock_req;
  logic       pll_locked;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [1:0] retry_cnt;

  modport master (
    output relock_req, pll_locked,
    input  pll_rst, core_rst, ready, fail, lock_lost, retry_cnt
  );

  modport slave (
    input  relock_req, pll_locked,
    output pll_rst, core_rst, ready, fail, lock_lost, retry_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Sequences the core PLL out of reset, qualifies its lock, releases the
//   core reset after lock has been stable, and supervises lock afterwards.
//   Runs entirely on refclk so it stays alive while the PLL outputs are dead.
//
// Ports
//   refclk  50 MHz reference clock (only clock)
//   rst     synchronous active-high reset
//   bus     pll_lock_sequencer_if.slave (relock_req, pll_locked in;
//           pll_rst, core_rst, ready, fail, lock_lost, retry_cnt out)
//
// States
//   state       | meaning
//   RESET_PLL   | pll_rst asserted for RST_PULSE_CYC cycles
//   WAIT_LOCK   | pll_rst released, waiting for lock or timeout
//   STABLE      | lock seen, counting consecutive locked cycles
//   RELEASE     | lock qualified, core_rst held for RELEASE_DELAY_CYC more
//   RUN         | core_rst released, ready high, lock supervised
//   FAIL        | retries exhausted, PLL held in reset until relock_req/rst
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYC     = 16,
  parameter int LOCK_TIMEOUT_CYC  = 65536,
  parameter int LOCK_STABLE_CYC   = 1024,
  parameter int RELEASE_DELAY_CYC = 64,
  parameter int MAX_RETRIES       = 3
) (
  input logic                 refclk,
  input logic                 rst,
  pll_lock_sequencer_if.slave bus
);

  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CD  = (LOCK_STABLE_CYC > RELEASE_DELAY_CYC) ? LOCK_STABLE_CYC : RELEASE_DELAY_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  // Terminal-count values; the counter starts at 0 on state entry.
  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_DELAY_CYC - 1);
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic          sync1_q, lk_q;
  logic          pll_rst_q, pll_rst_d;
  logic          core_rst_q, core_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          lock_lost_q, lock_lost_d;
  logic          lock_loss;
  logic          restart;
  logic          counting;

  // Two-flop synchronizer; lk_q is the only lock signal the FSM looks at.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= bus.pll_locked;
      lk_q    <= sync1_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      core_rst_q  <= core_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    lock_loss   = (state_q == S_RUN) && !lk_q;

    // Lock loss in RUN outranks relock_req so the loss is still reported.
    if (lock_loss) begin
      state_d     = S_RESET_PLL;
      lock_lost_d = 1'b1;
    end else if (bus.relock_req) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = S_RESET_PLL;
            end
          end
        end
        S_STABLE: begin
          if (!lk_q)                     state_d = S_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (!lk_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == RELEASE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN:   state_d = S_RUN;
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET_PLL;
      endcase
    end

    // Counter clears on every entry, including a relock into RESET_PLL itself.
    restart  = lock_loss || bus.relock_req || (state_d != state_q);
    counting = (state_q == S_RESET_PLL) || (state_q == S_WAIT_LOCK) ||
               (state_q == S_STABLE)    || (state_q == S_RELEASE);
    if (restart)       cnt_d = '0;
    else if (counting) cnt_d = cnt_q + 1'b1;
    else               cnt_d = cnt_q;

    // Outputs are registered from the next state so they switch on the entry edge.
    pll_rst_d  = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    core_rst_d = (state_d != S_RUN);
    ready_d    = (state_d == S_RUN);
    fail_d     = (state_d == S_FAIL);
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed bench: dut_a uses default parameters, dut_b a 32-cycle lock
//   timeout to exercise retries and FAIL. Inputs change and outputs are
//   sampled on the falling edge; cyc counts rising edges.
module tb_pll_lock_sequencer;

  logic refclk;
  logic rst_a, rst_b;
  int   cyc;
  int   vectors;
  int   miscompares;

  pll_lock_sequencer_if ifa ();
  pll_lock_sequencer_if ifb ();

  pll_lock_sequencer dut_a (
    .refclk (refclk),
    .rst    (rst_a),
    .bus    (ifa)
  );

  pll_lock_sequencer #(
    .LOCK_TIMEOUT_CYC (32)
  ) dut_b (
    .refclk (refclk),
    .rst    (rst_b),
    .bus    (ifb)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: observed cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge refclk);
  endtask

  task automatic adv_to(input int target);
    while (cyc < target) @(negedge refclk);
  endtask

  task automatic chk_reset_a(input string pfx);
    chk({pfx, "_pll_rst"},   32'(ifa.pll_rst),   1);
    chk({pfx, "_core_rst"},  32'(ifa.core_rst),  1);
    chk({pfx, "_ready"},     32'(ifa.ready),     0);
    chk({pfx, "_fail"},      32'(ifa.fail),      0);
    chk({pfx, "_lock_lost"}, 32'(ifa.lock_lost), 0);
    chk({pfx, "_retry"},     32'(ifa.retry_cnt), 0);
  endtask

  // Counts consecutive samples (starting with the current one) with pll_rst high.
  task automatic count_pll_rst(input bit sel_b, output int n);
    n = 0;
    while ((sel_b ? ifb.pll_rst : ifa.pll_rst) === 1'b1 && n < 100) begin
      n++;
      nxt();
    end
  endtask

  int t0, t1, d, r, n;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_a          = 1'b1;
    rst_b          = 1'b1;
    ifa.relock_req = 1'b0;
    ifa.pll_locked = 1'b0;
    ifb.relock_req = 1'b0;
    ifb.pll_locked = 1'b0;
    repeat (3) nxt();

    // 1: nominal lock
    chk_reset_a("t1_reset");
    t0    = cyc;
    rst_a = 1'b0;
    count_pll_rst(1'b0, n);
    chk("t1_pll_rst_len", 32'(n), 16);
    adv_to(t0 + 100);
    ifa.pll_locked = 1'b1;
    while (ifa.core_rst !== 1'b0 && cyc < t0 + 3000) nxt();
    chk("t1_release_cyc", 32'(cyc - t0), 1191);
    chk("t1_ready",       32'(ifa.ready),     1);
    chk("t1_pll_rst",     32'(ifa.pll_rst),   0);
    chk("t1_retry",       32'(ifa.retry_cnt), 0);

    // 2: lock glitch during STABLE
    rst_a          = 1'b1;
    ifa.pll_locked = 1'b0;
    nxt();
    t0    = cyc;
    rst_a = 1'b0;
    adv_to(t0 + 50);
    ifa.pll_locked = 1'b1;
    adv_to(t0 + 550);
    ifa.pll_locked = 1'b0;
    adv_to(t0 + 553);
    ifa.pll_locked = 1'b1;
    t1 = cyc;
    nxt();
    chk("t2_core_rst_held", 32'(ifa.core_rst), 1);
    while (ifa.core_rst !== 1'b0 && cyc < t1 + 3000) nxt();
    chk("t2_release_cyc", 32'(cyc - t1), 1091);
    chk("t2_retry",       32'(ifa.retry_cnt), 0);

    // 3: timeout, retries and FAIL (dut_b, lock never arrives)
    t0    = cyc;
    rst_b = 1'b0;
    count_pll_rst(1'b1, n);
    chk("t3_pll_rst_len0", 32'(n), 16);
    adv_to(t0 + 47);
    chk("t3_retry_pre",  32'(ifb.retry_cnt), 0);
    chk("t3_pll_rst_pre",32'(ifb.pll_rst),   0);
    adv_to(t0 + 48);
    chk("t3_retry1",     32'(ifb.retry_cnt), 1);
    count_pll_rst(1'b1, n);
    chk("t3_pll_rst_len1", 32'(n), 16);
    adv_to(t0 + 96);
    chk("t3_retry2",     32'(ifb.retry_cnt), 2);
    chk("t3_pll_rst2",   32'(ifb.pll_rst),   1);
    adv_to(t0 + 144);
    chk("t3_retry3",     32'(ifb.retry_cnt), 3);
    adv_to(t0 + 191);
    chk("t3_fail_pre",   32'(ifb.fail),      0);
    chk("t3_pll_rst_lo", 32'(ifb.pll_rst),   0);
    adv_to(t0 + 192);
    chk("t3_fail",       32'(ifb.fail),      1);
    chk("t3_fail_prst",  32'(ifb.pll_rst),   1);
    chk("t3_fail_crst",  32'(ifb.core_rst),  1);
    chk("t3_fail_ready", 32'(ifb.ready),     0);
    adv_to(t0 + 230);
    chk("t3_fail_held",  32'(ifb.fail),      1);
    ifb.relock_req = 1'b1;
    nxt();
    ifb.relock_req = 1'b0;
    chk("t3_relock_fail",  32'(ifb.fail),      0);
    chk("t3_relock_retry", 32'(ifb.retry_cnt), 0);
    count_pll_rst(1'b1, n);
    chk("t3_pll_rst_len2", 32'(n), 16);

    // 4: lock loss in RUN
    d = cyc;
    ifa.pll_locked = 1'b0;
    nxt();
    chk("t4_ready_d1",  32'(ifa.ready),     1);
    chk("t4_ll_d1",     32'(ifa.lock_lost), 0);
    nxt();
    chk("t4_ready_d2",  32'(ifa.ready),     1);
    chk("t4_ll_d2",     32'(ifa.lock_lost), 0);
    nxt();
    chk("t4_ll_d3",     32'(ifa.lock_lost), 1);
    chk("t4_crst_d3",   32'(ifa.core_rst),  1);
    chk("t4_ready_d3",  32'(ifa.ready),     0);
    chk("t4_prst_d3",   32'(ifa.pll_rst),   1);
    nxt();
    chk("t4_ll_d4",     32'(ifa.lock_lost), 0);
    ifa.pll_locked = 1'b1;
    while (ifa.ready !== 1'b1 && cyc < d + 3000) nxt();
    chk("t4_relock_cyc", 32'(cyc - d), 1108);
    chk("t4_retry",      32'(ifa.retry_cnt), 0);

    // 5a: relock_req alone in RUN
    r = cyc;
    ifa.relock_req = 1'b1;
    nxt();
    ifa.relock_req = 1'b0;
    chk("t5a_ll",    32'(ifa.lock_lost), 0);
    chk("t5a_ready", 32'(ifa.ready),     0);
    chk("t5a_crst",  32'(ifa.core_rst),  1);
    chk("t5a_prst",  32'(ifa.pll_rst),   1);
    while (ifa.ready !== 1'b1 && cyc < r + 3000) nxt();
    chk("t5a_relock_cyc", 32'(cyc - r), 1106);

    // 5b: relock_req coincident with lock loss
    d = cyc;
    ifa.pll_locked = 1'b0;
    nxt();
    nxt();
    ifa.relock_req = 1'b1;
    nxt();
    ifa.relock_req = 1'b0;
    chk("t5b_ll",    32'(ifa.lock_lost), 1);
    chk("t5b_ready", 32'(ifa.ready),     0);
    chk("t5b_prst",  32'(ifa.pll_rst),   1);
    nxt();
    chk("t5b_ll_d4", 32'(ifa.lock_lost), 0);
    ifa.pll_locked = 1'b1;

    // 6: synchronous reset mid-RELEASE
    adv_to(d + 1050);
    chk("t6_release_crst", 32'(ifa.core_rst), 1);
    chk("t6_release_prst", 32'(ifa.pll_rst),  0);
    chk("t6_release_rdy",  32'(ifa.ready),    0);
    rst_a = 1'b1;
    nxt();
    rst_a = 1'b0;
    chk_reset_a("t6_reset");
    count_pll_rst(1'b0, n);
    chk("t6_pll_rst_len", 32'(n), 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
